// File: rtl/button_press_classifier.sv
// Turns a debounced button level into discrete short / double / long press pulses.
// Valid/ready: none; btn_in is sampled every cycle and every output is a registered level or one-cycle pulse.
module button_press_classifier #(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 25_000_000,
  parameter int CNT_W             = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       pressed,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic       held,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam int MAX_CYC = (LONG_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_CYCLES : DOUBLE_GAP_CYCLES;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             prev;
  logic             rise;

  // prev resets high so a button held through reset is ignored until re-pressed
  assign rise      = btn_in & ~prev;
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= 1'b1;
      pressed      <= 1'b0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      prev         <= btn_in;
      pressed      <= btn_in;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESS1: begin
          if (!btn_in) begin
            state <= GAP;
            cnt   <= CNT_ONE;
          end else if (cnt >= LONG_LAST) begin
            long_press <= 1'b1;
            held       <= 1'b1;
            state      <= LONG_HOLD;
            cnt        <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        GAP: begin
          // a short press is only reported once the double-press window has closed
          if (btn_in) begin
            state <= PRESS2;
            cnt   <= CNT_ONE;
          end else if (cnt >= GAP_LAST) begin
            short_press <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESS2: begin
          if (!btn_in) begin
            double_press <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end else if (cnt >= LONG_LAST) begin
            // first press was short, second one turned long
            short_press <= 1'b1;
            long_press  <= 1'b1;
            held        <= 1'b1;
            state       <= LONG_HOLD;
            cnt         <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        LONG_HOLD: begin
          if (!btn_in) begin
            held  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          held  <= 1'b0;
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Vector-table bench for button_press_classifier with LONG_CYCLES=8, DOUBLE_GAP_CYCLES=4.
module tb_button_press_classifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       pressed, short_press, double_press, long_press, held;
  logic [2:0] state_dbg;

  button_press_classifier #(
    .LONG_CYCLES      (8),
    .DOUBLE_GAP_CYCLES(4),
    .CNT_W            (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .pressed     (pressed),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .held        (held),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // expected word layout: {pressed, short_press, double_press, long_press, held}
  typedef struct {
    logic       rst;
    logic       btn;
    logic [4:0] exp;
    int         tag;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         cur_tag = 0;
  int         checks = 0;
  int         errors = 0;
  logic       done = 1'b0;
  string      tag_names[10] = '{"held_thru_reset", "short", "double", "seven_high",
                                "long", "gap3", "gap4", "reset_mid", "press2_long", "random_double"};

  task automatic add(input logic r, input logic b, input int n, input logic h);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst = r;
      v.btn = b;
      v.exp = {(r ? 1'b0 : b), 3'b000, h};
      v.tag = cur_tag;
      vecs.push_back(v);
    end
  endtask

  task automatic pulse(input logic b, input logic s, input logic d, input logic l, input logic h);
    vec_t v;
    v.rst = 1'b0;
    v.btn = b;
    v.exp = {b, s, d, l, h};
    v.tag = cur_tag;
    vecs.push_back(v);
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: vector sequence did not complete within 5000 cycles");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
    end
  end

  initial begin
    vec_t       v;
    logic [4:0] got;
    logic [4:0] e;
    int         h1, g, h2;

    // held through reset: no events, pressed follows btn once reset drops
    cur_tag = 0;
    add(1, 1, 3, 0);
    add(0, 1, 20, 0);
    add(0, 0, 6, 0);
    // short press: pulse after the 4th low sample
    cur_tag = 1;
    add(0, 1, 3, 0); add(0, 0, 3, 0); pulse(0, 1, 0, 0, 0); add(0, 0, 2, 0);
    // double press, then a new press right after the decision edge
    cur_tag = 2;
    add(0, 1, 3, 0); add(0, 0, 2, 0); add(0, 1, 3, 0); pulse(0, 0, 1, 0, 0);
    add(0, 1, 2, 0); add(0, 0, 3, 0); pulse(0, 1, 0, 0, 0); add(0, 0, 2, 0);
    // one below the long threshold is still short
    cur_tag = 3;
    add(0, 1, 7, 0); add(0, 0, 3, 0); pulse(0, 1, 0, 0, 0); add(0, 0, 2, 0);
    // long press held to 20 samples
    cur_tag = 4;
    add(0, 1, 7, 0); pulse(1, 0, 0, 1, 1); add(0, 1, 12, 1); add(0, 0, 1, 0); add(0, 0, 4, 0);
    // gap of 3 lows still joins a double
    cur_tag = 5;
    add(0, 1, 3, 0); add(0, 0, 3, 0); add(0, 1, 3, 0); pulse(0, 0, 1, 0, 0); add(0, 0, 4, 0);
    // gap of 4 lows closes the window; the next high starts a fresh press
    cur_tag = 6;
    add(0, 1, 3, 0); add(0, 0, 3, 0); pulse(0, 1, 0, 0, 0);
    add(0, 1, 2, 0); add(0, 0, 3, 0); pulse(0, 1, 0, 0, 0); add(0, 0, 2, 0);
    // reset in GAP drops the pending short
    cur_tag = 7;
    add(0, 1, 3, 0); add(0, 0, 2, 0); add(1, 0, 1, 0); add(0, 0, 10, 0);
    // second press goes long: short and long together
    cur_tag = 8;
    add(0, 1, 3, 0); add(0, 0, 2, 0); add(0, 1, 7, 0); pulse(1, 1, 0, 1, 1);
    add(0, 1, 2, 1); add(0, 0, 1, 0); add(0, 0, 2, 0);
    // random double presses inside both windows
    cur_tag = 9;
    for (int k = 0; k < 4; k++) begin
      h1 = $urandom_range(1, 7);
      g  = $urandom_range(1, 3);
      h2 = $urandom_range(1, 7);
      add(0, 1, h1, 0); add(0, 0, g, 0); add(0, 1, h2, 0); pulse(0, 0, 1, 0, 0); add(0, 0, 4, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      rst    = v.rst;
      btn_in = v.btn;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      got = {pressed, short_press, double_press, long_press, held};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s step %0d: got p/s/d/l/h=%b expected %b", tag_names[v.tag], i, got, e);
      end
      if (v.rst) begin
        checks++;
        if (state_dbg !== 3'd0) begin
          errors++;
          $display("FAIL %s step %0d: reset state_dbg=%0d expected IDLE", tag_names[v.tag], i, state_dbg);
        end
      end
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
